// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  localparam int MEM_LAT_MAX = 7;
  localparam int STARVE_W    = 4;
  localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

  // Fetch addresses are byte addresses; memory is word addressed.
  localparam int WORD_SHIFT  = 2;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// CPU-side handshakes and memory-side command bus of the arbiter.
// slave  = the arbiter's view, master = the CPU/memory environment's view.
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              arb_busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, arb_busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, arb_busy
  );
endinterface

// File: rtl/mips_mem_arbiter_lat_timer.sv
// Loadable down-counter timing the memory read latency of one access.
// expire is high in the cycle where the loaded count has run down to zero.
module mips_lat_timer
  import mips_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LAT_W-1:0] lat,
  output logic             expire
);

  logic [LAT_W-1:0] lat_cnt;
  logic             active;

  // Load on start, then count down once per cycle until expiry.
  // NOTE: clocked state uses non-blocking (<=) so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
      active  <= 1'b0;
    end else if (start) begin
      lat_cnt <= lat;
      active  <= 1'b1;
    end else if (active) begin
      if (lat_cnt == '0) active  <= 1'b0;
      else               lat_cnt <= lat_cnt - 1'b1;
    end
  end

  assign expire = active && (lat_cnt == '0);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data
// access. Data wins, except that fetch is forced through after STARVE_MAX
// consecutive data grants that overtook a waiting fetch.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mips_mem_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT);

  arb_state_t          state, state_next;
  logic [STARVE_W-1:0] starve_cnt, starve_next;
  logic                grant_d, grant_i;
  logic                expire;
  logic                is_store;
  logic [ADDR_W-1:0]   fetch_word;

  assign fetch_word = bus.if_addr >> WORD_SHIFT;

  // Arbitration and next-state decision; requests are only looked at in IDLE.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && starve_cnt == STARVE_LIM)) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
          // A D grant over a waiting fetch implies starve_cnt < STARVE_LIM,
          // so the increment cannot pass the saturation point.
          if (bus.if_req) starve_next = starve_cnt + 1'b1;
        end else if (bus.if_req) begin
          grant_i     = 1'b1;
          state_next  = BUSY_I;
          starve_next = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Registered memory command, issued in the cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      is_store      <= 1'b0;
    end else begin
      bus.ram_en <= grant_d | grant_i;
      bus.ram_we <= grant_d & bus.d_we;
      if (grant_d) begin
        bus.ram_addr  <= bus.d_addr;
        bus.ram_wdata <= bus.d_wdata;
        is_store      <= bus.d_we;
      end else if (grant_i) begin
        bus.ram_addr  <= fetch_word;
        bus.ram_wdata <= DATA_W'(0);
        is_store      <= 1'b0;
      end
    end
  end

  mips_lat_timer u_lat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (grant_d | grant_i),
    .lat    (LAT_LOAD),
    .expire (expire)
  );

  // Completion is combinational from state so reset kills it immediately.
  assign bus.if_ready = (state == BUSY_I) && expire;
  assign bus.d_ready  = (state == BUSY_D) && expire;
  assign bus.if_rdata = bus.if_ready ? bus.ram_rdata : '0;
  assign bus.d_rdata  = (bus.d_ready && !is_store) ? bus.ram_rdata : '0;
  assign bus.arb_busy = (state != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench: transaction-level reference model for the MEM_LAT=1
// arbiter checked every cycle, directed scenarios with literal expectations,
// and a MEM_LAT=3 instance for back-to-back fetch spacing.
module tb_mips_mem_arbiter;

  localparam int LAT1 = 1;
  localparam int SM1  = 4;
  localparam int LAT3 = 3;

  logic clk;
  logic rst_n;

  mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_MAX(SM1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3), .STARVE_MAX(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environments ----------------
  logic [31:0] mem1 [64];
  logic [31:0] pipe1;
  logic [31:0] mem3 [64];
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (bus1.ram_en && bus1.ram_we) mem1[bus1.ram_addr[5:0]] <= bus1.ram_wdata;
    pipe1 <= (bus1.ram_en && !bus1.ram_we) ? mem1[bus1.ram_addr[5:0]] : $urandom;
  end
  assign bus1.ram_rdata = pipe1;

  always @(posedge clk) begin
    if (bus3.ram_en && bus3.ram_we) mem3[bus3.ram_addr[5:0]] <= bus3.ram_wdata;
    pipe3[0] <= (bus3.ram_en && !bus3.ram_we) ? mem3[bus3.ram_addr[5:0]] : $urandom;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.ram_rdata = pipe3[2];

  // ---------------- reference model (bus1) ----------------
  // Tracks the cycle index at which the last grant was sampled; everything
  // observable follows from the phase (current cycle - grant cycle):
  // phase 1 = command cycle, phase LAT1+1 = ready cycle.
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  bit          m_active = 0;
  int          m_g = 0;
  bit          m_isd, m_we, m_gd, m_gi;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_starve = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_starve = 0;
    end else begin
      if (!m_active || cyc >= m_g + LAT1 + 2) begin
        m_gd = bus1.d_req && !(bus1.if_req && m_starve == SM1);
        m_gi = !m_gd && bus1.if_req;
        if (m_gd || m_gi) begin
          m_active = 1;
          m_g      = cyc;
          m_isd    = m_gd;
          if (m_gd) begin
            m_we    = bus1.d_we;
            m_addr  = bus1.d_addr;
            m_wdata = bus1.d_wdata;
            if (bus1.if_req) m_starve = (m_starve < SM1) ? m_starve + 1 : SM1;
          end else begin
            m_we     = 0;
            m_addr   = bus1.if_addr >> 2;
            m_wdata  = 0;
            m_starve = 0;
          end
          m_rdata = m_we ? 32'h0 : ref_mem[m_addr[5:0]];
          if (m_we) ref_mem[m_addr[5:0]] = m_wdata;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of every bus1 output against the model.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      int  ph;
      bit  act, e_en, e_ir, e_dr;
      ph   = cyc - m_g;
      act  = m_active && ph >= 1 && ph <= LAT1 + 1;
      e_en = act && ph == 1;
      e_ir = act && ph == LAT1 + 1 && !m_isd;
      e_dr = act && ph == LAT1 + 1 && m_isd;
      check("m_busy",     bus1.arb_busy, act);
      check("m_ram_en",   bus1.ram_en,   e_en);
      check("m_if_ready", bus1.if_ready, e_ir);
      check("m_d_ready",  bus1.d_ready,  e_dr);
      check("m_if_rdata", bus1.if_rdata, e_ir ? m_rdata : 32'h0);
      check("m_d_rdata",  bus1.d_rdata,  (e_dr && !m_we) ? m_rdata : 32'h0);
      if (e_en) begin
        check("m_ram_we",    bus1.ram_we,    m_we);
        check("m_ram_addr",  bus1.ram_addr,  m_addr);
        check("m_ram_wdata", bus1.ram_wdata, m_wdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_en"},    bus1.ram_en,    0);
    check({tag, "_ram_we"},    bus1.ram_we,    0);
    check({tag, "_ram_addr"},  bus1.ram_addr,  0);
    check({tag, "_ram_wdata"}, bus1.ram_wdata, 0);
    check({tag, "_if_ready"},  bus1.if_ready,  0);
    check({tag, "_d_ready"},   bus1.d_ready,   0);
    check({tag, "_if_rdata"},  bus1.if_rdata,  0);
    check({tag, "_d_rdata"},   bus1.d_rdata,   0);
    check({tag, "_busy"},      bus1.arb_busy,  0);
  endtask

  // Waits (bounded) for a ready pulse on bus1; returns its cycle number.
  task automatic wait_rdy(input bit is_d, input string name, output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_d ? bus1.d_ready : bus1.if_ready) begin
        t = int'($time / 10);
        break;
      end
    end
    check(name, is_d ? bus1.d_ready : bus1.if_ready, 1);
  endtask

  task automatic new_d();
    bus1.d_we    = 1'($urandom_range(0, 1));
    bus1.d_addr  = $urandom;
    bus1.d_wdata = $urandom;
  endtask

  task automatic new_i();
    bus1.if_addr = $urandom;
  endtask

  // ---------------- main sequence ----------------
  bit          dr, ir;
  int          t_d, t_i;
  bit          gseq [10];
  int          n_g;
  int          en_t [3];
  logic [31:0] en_a [3];
  int          n_en, n_rdy;

  initial begin
    {bus1.if_req, bus1.d_req, bus1.d_we} = '0;
    bus1.if_addr = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
    {bus3.if_req, bus3.d_req, bus3.d_we} = '0;
    bus3.if_addr = '0; bus3.d_addr = '0; bus3.d_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem1[i]    <= v;
      ref_mem[i]  = v;
      mem3[i]    <= $urandom;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n  = 1'b1;
    chk_en = 1;

    // 1: single fetch, MEM_LAT=1
    tick();
    mem1[2]   <= 32'h1234;
    ref_mem[2] = 32'h1234;
    bus1.if_req  = 1'b1;
    bus1.if_addr = 32'h8;
    tick();
    @(negedge clk);
    check("t1_ram_en",   bus1.ram_en,   1);
    check("t1_ram_addr", bus1.ram_addr, 2);
    check("t1_ram_we",   bus1.ram_we,   0);
    @(negedge clk);
    check("t1_if_ready", bus1.if_ready, 1);
    check("t1_if_rdata", bus1.if_rdata, 32'h1234);
    tick();
    bus1.if_req = 1'b0;

    // 2: store
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 9; bus1.d_wdata = 6;
    tick();
    @(negedge clk);
    check("t2_ram_en",    bus1.ram_en,    1);
    check("t2_ram_we",    bus1.ram_we,    1);
    check("t2_ram_addr",  bus1.ram_addr,  9);
    check("t2_ram_wdata", bus1.ram_wdata, 6);
    @(negedge clk);
    check("t2_d_ready", bus1.d_ready, 1);
    check("t2_d_rdata", bus1.d_rdata, 0);
    tick();
    bus1.d_req = 1'b0;

    // 3: simultaneous requests, data first
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h11;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h40;
    tick();
    @(negedge clk);
    check("t3_first_addr", bus1.ram_addr, 32'h11);
    wait_rdy(1'b1, "t3_d_ready", t_d);
    tick();
    bus1.d_req = 1'b0;
    wait_rdy(1'b0, "t3_if_ready", t_i);
    check("t3_gap", t_i - t_d, LAT1 + 2);
    tick();
    bus1.if_req = 1'b0;

    // 4: starvation bound, both held continuously
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h33;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h80;
    n_g = 0;
    for (int i = 0; i < 100 && n_g < 10; i++) begin
      @(negedge clk);
      if (bus1.ram_en) begin
        gseq[n_g] = (bus1.ram_addr == 32'h20);
        n_g++;
      end
    end
    check("t4_grants", n_g, 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("t4_grant%0d_is_fetch", i), gseq[i], (i % 5) == 4);
    tick();
    bus1.d_req = 1'b0; bus1.if_req = 1'b0;
    repeat (6) tick();

    // 5: reset during BUSY_D
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 7;
    tick();
    @(negedge clk);
    check("t5_busy_before", bus1.arb_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_rst");
    bus1.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_d_ready", bus1.d_ready,  0);
      check("t5_idle",       bus1.arb_busy, 0);
    end

    // 6: MEM_LAT=3 back-to-back fetches at 0x0, 0x4, 0x8
    for (int i = 0; i < 3; i++) begin
      en_t[i] = 0;
      en_a[i] = 32'hffff_ffff;
    end
    tick();
    bus3.if_addr = 32'h0;
    bus3.if_req  = 1'b1;
    n_en = 0; n_rdy = 0;
    for (int i = 0; i < 60 && n_rdy < 3; i++) begin
      @(negedge clk);
      if (bus3.ram_en) begin
        if (n_en < 3) begin
          en_t[n_en] = int'($time / 10);
          en_a[n_en] = bus3.ram_addr;
        end
        n_en++;
      end
      if (bus3.if_ready) begin
        n_rdy++;
        tick();
        bus3.if_addr = bus3.if_addr + 32'h4;
        if (n_rdy == 3) bus3.if_req = 1'b0;
      end
    end
    check("t6_readies", n_rdy, 3);
    check("t6_cmds",    n_en,  3);
    for (int i = 0; i < 3; i++) check($sformatf("t6_addr%0d", i), en_a[i], i);
    check("t6_gap01", en_t[1] - en_t[0], LAT3 + 2);
    check("t6_gap12", en_t[2] - en_t[1], LAT3 + 2);

    // Random traffic on bus1, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      dr = bus1.d_ready;
      ir = bus1.if_ready;
      tick();
      if (bus1.d_req) begin
        if (dr) begin
          bus1.d_req = 1'($urandom_range(0, 1));
          new_d();
        end else if ($urandom_range(0, 31) == 0) bus1.d_req = 1'b0;
        else if ($urandom_range(0, 15) == 0) new_d();
      end else if ($urandom_range(0, 2) != 0) begin
        bus1.d_req = 1'b1;
        new_d();
      end
      if (bus1.if_req) begin
        if (ir) begin
          bus1.if_req = 1'($urandom_range(0, 1));
          new_i();
        end else if ($urandom_range(0, 31) == 0) bus1.if_req = 1'b0;
        else if ($urandom_range(0, 15) == 0) new_i();
      end else if ($urandom_range(0, 2) != 0) begin
        bus1.if_req = 1'b1;
        new_i();
      end
    end
    bus1.d_req = 1'b0; bus1.if_req = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
